wb_arbiter_sb: RTL and testbench

- Shares the register file's single write port between two writeback requesters: ALU result (A) and memory load return (M).
- Fair round-robin arbitration with a valid/ready handshake; the winner is registered onto the write port.
- Keeps a per-register busy scoreboard. Issue reserves a destination; the committed write clears it; issue/hazard logic reads busy.
- Sits between execute/memory stages and register_file write_addr/write_data.

---
 rtl/wb_arbiter_sb_pkg.sv | 18 +
 rtl/wb_arbiter_sb_rr_arb2.sv | 35 +++
 rtl/wb_arbiter_sb.sv | 118 +++++++++++
 tb/tb_wb_arbiter_sb.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_sb_pkg.sv
// Shared definitions for the writeback arbiter / scoreboard slice.
//   ADDR_W, DATA_W, NUM_REGS : register file geometry (r0 hardwired zero)
//   REG_ZERO                 : address of the hardwired-zero register
//   req_e                    : requester identity, used as round-robin pointer
package wb_arbiter_sb_pkg;

  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = 4'd0;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_M = 1'b1
  } req_e;

endpackage

// File: rtl/wb_arbiter_sb_rr_arb2.sv
// Two-input round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_valid    : request vector, bit 0 = A, bit 1 = M
//   o_grant    : one-hot (or zero) grant vector, combinational
// The pointer remembers the last winner; on a tie the other requester wins.
// After reset the pointer is M so A wins the first tie.
module rr_arb2
  import wb_arbiter_sb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);

  req_e r_last;

  always_comb begin
    o_grant = i_valid;
    if (i_valid == 2'b11) begin
      o_grant = (r_last == REQ_M) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= REQ_M;
    end else if (o_grant[0]) begin
      r_last <= REQ_A;
    end else if (o_grant[1]) begin
      r_last <= REQ_M;
    end
  end

endmodule

// File: rtl/wb_arbiter_sb.sv
// Writeback arbiter with register busy scoreboard.
// Shares the register file's single write port between the ALU (A) and the
// load return path (M), registers the winner onto the write port, and tracks
// which registers have a pending write.
//   clk, rst_n                   : clock, asynchronous active-low reset
//   a_valid/a_ready/a_addr/a_data: ALU writeback handshake
//   m_valid/m_ready/m_addr/m_data: load writeback handshake
//   iss_valid/iss_addr           : issue stage reserving a destination
//   write_addr/write_data        : to register file (write_addr 0 = no write)
//   busy                         : pending-write flags, bit 0 always 0
//   sb_err                       : sticky illegal scoreboard operation flag
module wb_arbiter_sb
  import wb_arbiter_sb_pkg::*;
#(
  parameter int unsigned DATA_W   = wb_arbiter_sb_pkg::DATA_W,
  parameter int unsigned ADDR_W   = wb_arbiter_sb_pkg::ADDR_W,
  parameter int unsigned NUM_REGS = 2 ** ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                m_valid,
  output logic                m_ready,
  input  logic [ADDR_W-1:0]   m_addr,
  input  logic [DATA_W-1:0]   m_data,
  input  logic                iss_valid,
  input  logic [ADDR_W-1:0]   iss_addr,
  output logic [ADDR_W-1:0]   write_addr,
  output logic [DATA_W-1:0]   write_data,
  output logic [NUM_REGS-1:0] busy,
  output logic                sb_err
);

  localparam logic [ADDR_W-1:0]   ADDR_ZERO = ADDR_W'(REG_ZERO);
  localparam logic [NUM_REGS-1:0] ONE_HOT0  = NUM_REGS'(1);

  logic [1:0]          w_req;
  logic [1:0]          w_grant;
  logic [ADDR_W-1:0]   r_write_addr;
  logic [DATA_W-1:0]   r_write_data;
  logic [NUM_REGS-1:0] r_busy;
  logic                r_sb_err;

  logic                w_commit;
  logic                w_reserve;
  logic [NUM_REGS-1:0] w_clr_vec;
  logic [NUM_REGS-1:0] w_set_vec;
  logic [NUM_REGS-1:0] w_busy_d;
  logic                w_err_waw;
  logic                w_err_clr;

  // Readies are forced low while reset is asserted.
  assign w_req = {m_valid, a_valid} & {2{rst_n}};

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_req),
    .o_grant (w_grant)
  );

  assign a_ready = w_grant[0];
  assign m_ready = w_grant[1];

  // Write port register: one-cycle latency from grant to register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write_addr <= '0;
      r_write_data <= '0;
    end else if (w_grant[0]) begin
      r_write_addr <= a_addr;
      r_write_data <= a_data;
    end else if (w_grant[1]) begin
      r_write_addr <= m_addr;
      r_write_data <= m_data;
    end else begin
      r_write_addr <= '0;
    end
  end

  // Scoreboard: the write presented this cycle commits on the coming edge.
  always_comb begin
    w_commit  = (r_write_addr != ADDR_ZERO);
    w_reserve = iss_valid && (iss_addr != ADDR_ZERO);
    w_clr_vec = '0;
    w_set_vec = '0;
    if (w_commit) begin
      w_clr_vec = ONE_HOT0 << r_write_addr;
    end
    if (w_reserve) begin
      w_set_vec = ONE_HOT0 << iss_addr;
    end
    // Set after clear: a reissue on the commit edge leaves the new producer owning it.
    w_busy_d  = ((r_busy & ~w_clr_vec) | w_set_vec) & ~ONE_HOT0;
    w_err_waw = w_reserve && r_busy[iss_addr] &&
                !(w_commit && (r_write_addr == iss_addr));
    w_err_clr = w_commit && !r_busy[r_write_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= '0;
      r_sb_err <= 1'b0;
    end else begin
      r_busy   <= w_busy_d;
      r_sb_err <= r_sb_err | w_err_waw | w_err_clr;
    end
  end

  assign write_addr = r_write_addr;
  assign write_data = r_write_data;
  assign busy       = r_busy;
  assign sb_err     = r_sb_err;

endmodule

// File: tb/tb_wb_arbiter_sb.sv
module tb_wb_arbiter_sb;

  logic        clk;
  logic        rst_n;
  logic        a_valid, m_valid, iss_valid;
  logic        a_ready, m_ready;
  logic [3:0]  a_addr, m_addr, iss_addr, write_addr;
  logic [31:0] a_data, m_data, write_data;
  logic [15:0] busy;
  logic        sb_err;

  wb_arbiter_sb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_addr     (m_addr),
    .m_data     (m_data),
    .iss_valid  (iss_valid),
    .iss_addr   (iss_addr),
    .write_addr (write_addr),
    .write_data (write_data),
    .busy       (busy),
    .sb_err     (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Reference model state: who won last (0 = A, 1 = M), the write on the port,
  // the set of registers with a pending write, and the sticky error.
  int          mdl_last;
  logic [3:0]  mdl_wa;
  logic [31:0] mdl_wd;
  bit          mdl_busy [16];
  bit          mdl_err;

  function automatic logic [15:0] mdl_busy_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = mdl_busy[i];
    return v;
  endfunction

  function automatic bit exp_a_ready();
    return a_valid && (!m_valid || mdl_last == 1);
  endfunction

  function automatic bit exp_m_ready();
    return m_valid && !(a_valid && (!m_valid || mdl_last == 1));
  endfunction

  task automatic mdl_reset();
    mdl_last = 1;
    mdl_wa   = 4'd0;
    mdl_wd   = 32'd0;
    mdl_err  = 1'b0;
    for (int i = 0; i < 16; i++) mdl_busy[i] = 1'b0;
  endtask

  task automatic idle_inputs();
    a_valid = 0; m_valid = 0; iss_valid = 0;
    a_addr = 0; m_addr = 0; iss_addr = 0;
    a_data = 0; m_data = 0;
  endtask

  // Advance one clock edge and apply the rules of the block to the model.
  task automatic step();
    bit         ga, gm;
    logic [3:0] old_wa;
    ga = exp_a_ready();
    gm = exp_m_ready();
    @(posedge clk);
    old_wa = mdl_wa;
    if (old_wa != 0 && !mdl_busy[old_wa]) mdl_err = 1'b1;
    if (iss_valid && iss_addr != 0 && mdl_busy[iss_addr] && iss_addr != old_wa) mdl_err = 1'b1;
    if (old_wa != 0) mdl_busy[old_wa] = 1'b0;
    if (iss_valid && iss_addr != 0) mdl_busy[iss_addr] = 1'b1;
    if (ga) begin
      mdl_wa = a_addr; mdl_wd = a_data; mdl_last = 0;
    end else if (gm) begin
      mdl_wa = m_addr; mdl_wd = m_data; mdl_last = 1;
    end else begin
      mdl_wa = 4'd0;
    end
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    a_valid = 1; m_valid = 1;
    #1;
    checks++;
    if (a_ready !== 1'b0 || m_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got a=%b m=%b want 0 0", a_ready, m_ready);
    end
    checks++;
    if (write_addr !== 4'd0 || write_data !== 32'd0) begin
      errors++; $display("FAIL reset_wport: got %h/%h want 0/0", write_addr, write_data);
    end
    checks++;
    if (busy !== 16'd0 || sb_err !== 1'b0) begin
      errors++; $display("FAIL reset_sb: got busy=%h err=%b want 0 0", busy, sb_err);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    a_valid = 1; a_addr = 4'd3; a_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (a_ready !== 1'b1 || m_ready !== 1'b0) begin
      errors++; $display("FAIL single_ready: got a=%b m=%b want 1 0", a_ready, m_ready);
    end
    step();
    a_valid = 0;
    checks++;
    if (write_addr !== 4'd3 || write_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_write: got %h/%h want 3/deadbeef", write_addr, write_data);
    end
    step();
    checks++;
    if (write_addr !== 4'd0 || write_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_after: got %h/%h want 0/deadbeef", write_addr, write_data);
    end
  endtask

  task automatic test_tie();
    logic [3:0] exp_addr;
    do_reset();
    a_valid = 1; a_addr = 4'd5; a_data = 32'h5555_0000;
    m_valid = 1; m_addr = 4'd6; m_data = 32'h6666_0000;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (a_ready !== ((i % 2) == 0) || m_ready !== ((i % 2) == 1)) begin
        errors++; $display("FAIL tie_grant%0d: got a=%b m=%b want a=%b", i, a_ready, m_ready,
                           (i % 2) == 0);
      end
      step();
      exp_addr = ((i % 2) == 0) ? 4'd5 : 4'd6;
      checks++;
      if (write_addr !== exp_addr) begin
        errors++; $display("FAIL tie_waddr%0d: got %0d want %0d", i, write_addr, exp_addr);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_lifecycle();
    do_reset();
    iss_valid = 1; iss_addr = 4'd7;
    step();
    iss_valid = 0;
    checks++;
    if (busy[7] !== 1'b1) begin
      errors++; $display("FAIL life_set: got busy[7]=%b want 1", busy[7]);
    end
    step();
    m_valid = 1; m_addr = 4'd7; m_data = 32'h0000_0777;
    step();
    m_valid = 0;
    checks++;
    if (busy[7] !== 1'b1 || write_addr !== 4'd7) begin
      errors++; $display("FAIL life_pending: got busy[7]=%b wa=%0d want 1 7", busy[7], write_addr);
    end
    step();
    checks++;
    if (busy[7] !== 1'b0 || sb_err !== 1'b0) begin
      errors++; $display("FAIL life_clear: got busy[7]=%b err=%b want 0 0", busy[7], sb_err);
    end
  endtask

  task automatic test_collision();
    do_reset();
    iss_valid = 1; iss_addr = 4'd4;
    step();
    iss_valid = 0;
    a_valid = 1; a_addr = 4'd4; a_data = 32'h44;
    step();
    a_valid = 0;
    iss_valid = 1; iss_addr = 4'd4;
    step();
    iss_valid = 0;
    checks++;
    if (busy[4] !== 1'b1 || sb_err !== 1'b0) begin
      errors++; $display("FAIL collision: got busy[4]=%b err=%b want 1 0", busy[4], sb_err);
    end
  endtask

  task automatic test_errors();
    do_reset();
    iss_valid = 1; iss_addr = 4'd2;
    step();
    checks++;
    if (sb_err !== 1'b0) begin
      errors++; $display("FAIL err_first_iss: got %b want 0", sb_err);
    end
    step();
    iss_valid = 0;
    step();
    step();
    checks++;
    if (sb_err !== 1'b1) begin
      errors++; $display("FAIL err_waw_sticky: got %b want 1", sb_err);
    end
    do_reset();
    a_valid = 1; a_addr = 4'd9; a_data = 32'h99;
    step();
    a_valid = 0;
    step();
    checks++;
    if (sb_err !== 1'b1) begin
      errors++; $display("FAIL err_nonbusy_write: got %b want 1", sb_err);
    end
    do_reset();
    iss_valid = 1; iss_addr = 4'd0;
    a_valid = 1; a_addr = 4'd0; a_data = 32'h1234;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      errors++; $display("FAIL err_zero_grant: got %b want 1", a_ready);
    end
    step();
    idle_inputs();
    checks++;
    if (write_addr !== 4'd0) begin
      errors++; $display("FAIL err_zero_waddr: got %0d want 0", write_addr);
    end
    step();
    checks++;
    if (busy !== 16'd0 || sb_err !== 1'b0) begin
      errors++; $display("FAIL err_zero_sb: got busy=%h err=%b want 0 0", busy, sb_err);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int r = 4; r < 7; r++) begin
      iss_valid = 1; iss_addr = 4'(r);
      step();
    end
    iss_addr = 4'd7;
    a_valid = 1; a_addr = 4'd5; a_data = 32'h5A5A;
    step();
    idle_inputs();
    checks++;
    if (busy !== 16'h00F0 || write_addr !== 4'd5) begin
      errors++; $display("FAIL arst_setup: got busy=%h wa=%0d want 00f0 5", busy, write_addr);
    end
    a_valid = 1; m_valid = 1; a_addr = 4'd5; m_addr = 4'd6;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (write_addr !== 4'd0 || busy !== 16'd0 || sb_err !== 1'b0) begin
      errors++; $display("FAIL arst_state: got wa=%0d busy=%h err=%b want 0 0 0",
                         write_addr, busy, sb_err);
    end
    checks++;
    if (a_ready !== 1'b0 || m_ready !== 1'b0) begin
      errors++; $display("FAIL arst_ready: got a=%b m=%b want 0 0", a_ready, m_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mdl_reset();
    #1;
    checks++;
    if (a_ready !== 1'b1 || m_ready !== 1'b0) begin
      errors++; $display("FAIL arst_first_tie: got a=%b m=%b want 1 0", a_ready, m_ready);
    end
    step();
    checks++;
    if (write_addr !== 4'd5) begin
      errors++; $display("FAIL arst_first_write: got %0d want 5", write_addr);
    end
    idle_inputs();
    step();
  endtask

  // Random traffic; a losing requester holds its request until granted.
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!a_valid && $urandom_range(1, 0) == 1) begin
        a_valid = 1; a_addr = 4'($urandom_range(15, 0)); a_data = $urandom;
      end
      if (!m_valid && $urandom_range(2, 0) == 0) begin
        m_valid = 1; m_addr = 4'($urandom_range(15, 0)); m_data = $urandom;
      end
      iss_valid = ($urandom_range(2, 0) == 0);
      iss_addr  = 4'($urandom_range(15, 0));
      #1;
      checks++;
      if (a_ready !== exp_a_ready() || m_ready !== exp_m_ready()) begin
        errors++; $display("FAIL rand_ready c=%0d: got a=%b m=%b want a=%b m=%b", c, a_ready,
                           m_ready, exp_a_ready(), exp_m_ready());
      end
      begin
        bit ga, gm;
        ga = exp_a_ready();
        gm = exp_m_ready();
        step();
        if (ga) a_valid = 0;
        if (gm) m_valid = 0;
      end
      checks++;
      if (write_addr !== mdl_wa || write_data !== mdl_wd) begin
        errors++; $display("FAIL rand_wport c=%0d: got %h/%h want %h/%h", c, write_addr,
                           write_data, mdl_wa, mdl_wd);
      end
      checks++;
      if (busy !== mdl_busy_vec() || sb_err !== mdl_err) begin
        errors++; $display("FAIL rand_sb c=%0d: got busy=%h err=%b want %h %b", c, busy, sb_err,
                           mdl_busy_vec(), mdl_err);
      end
      if (c == 200) begin
        do_reset();
      end
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    mdl_reset();
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_tie();
    test_lifecycle();
    test_collision();
    test_errors();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
